update_dispatcher: RTL
======================

# update_dispatcher

Host-side feeder for the arbitrage engine container. It buffers edge-weight updates (source vertex, destination vertex, weight) arriving from the host in a FIFO. It then presents them one at a time on the container's update port, and sequences the container's reset/done handshake so each update triggers exactly one Bellman-Ford plus cycle-detect pass. It sits between the host register interface and the container, and is the initiator for the container's update/done protocol.

## Interface
- VERT_W, default 6: vertex index width; drives u_src/u_dst.
- WEIGHT_W, default 32: edge weight width.
- DEPTH, default 16: FIFO entries; power of two, ≥2.
- LOAD_CYC, default 2: cycles c_reset is held high per run; ≥2.
- TIMEOUT, default 65535: max RUN cycles before abort; ≥1.

Ports:
- clk, in, 1: single clock, rising edge.
- reset_n, in, 1: asynchronous, active-low reset.
- wr_valid, in, 1: host update valid.
- wr_ready, out, 1: FIFO can accept; equals !full.
- wr_src, in, VERT_W: update source vertex.
- wr_dst, in, VERT_W: update destination vertex.
- wr_weight, in, WEIGHT_W: update weight.
- c_reset, out, 1: active-high synchronous reset to container.
- u_src, out, VERT_W: to container; stable for whole run.
- u_dst, out, VERT_W: to container; stable for whole run.
- u_e, out, WEIGHT_W: to container; stable for whole run.
- c_done, in, 1: container done; level, sticky until next c_reset.
- busy, out, 1: FSM not in IDLE.
- pending, out, log2(DEPTH)+1: FIFO occupancy.
- runs, out, 16: completed runs; wraps at 2^16.
- timeouts, out, 8: aborted runs; saturates at 255.
- err, out, 1: sticky; set on first timeout; cleared only by reset.

## Operation
- Reset values (reset_n low, asynchronous): FSM=IDLE, c_reset=1, u_*=0, FIFO empty (pending=0, wr_ready=1), runs=0, timeouts=0, err=0, busy=0.
- Push: wr_valid && wr_ready on a clock edge writes {wr_src, wr_dst, wr_weight} at the FIFO tail. When full, wr_ready=0 and wr_valid is ignored; no data is lost or overwritten.
- FSM states:
  - IDLE: c_reset=0. If pending>0, pop the head into the u_* registers and go to LOAD.
  - LOAD: c_reset=1 for exactly LOAD_CYC cycles (cycle counter), then go to RUN.
  - RUN: c_reset=0. Run counter increments each cycle.
    - c_done=1: runs++ and go to IDLE.
    - Counter reaches TIMEOUT with c_done=0: timeouts++ (saturating), err=1, go to IDLE.
- u_* change only on pop (IDLE→LOAD) and hold through LOAD and RUN. The container samples them on its first cycle after c_reset falls.
- Push and pop in the same cycle: both occur; pending is unchanged. When pending was DEPTH, no push happens because wr_ready=0.
- FIFO pointers are log2(DEPTH) bits and wrap modulo DEPTH. Occupancy is a separate counter.
- c_done is ignored outside RUN.
- Mid-operation reset_n assertion: immediate return to reset values, FIFO contents discarded, c_reset=1 asynchronously.

## Timing
- Update accepted into an empty FIFO while in IDLE at edge T: pending=1 after T. Pop at T+1 with u_* valid after T+1. c_reset=1 for cycles T+1..T+LOAD_CYC, registered. RUN begins at T+LOAD_CYC+1.
- c_done sampled high at RUN edge R: runs increments and busy=0 after R. The next pop can occur at R+1.
- Back-to-back updates: minimum per-update overhead is 2 + LOAD_CYC cycles plus container runtime.
- All outputs are registered except wr_ready and busy, which are decoded from registered state.

## Test plan
- Reset: reset_n=0 asynchronously mid-clock → c_reset=1, u_*=0, pending=0, wr_ready=1, runs=0 with no clock edge.
- Single update: push (3,5,0x00000100) → u_src=3, u_dst=5, u_e=0x100 one cycle later. c_reset high for exactly 2 cycles. Model raises c_done 20 cycles after c_reset falls → runs=1, busy=0.
- Full FIFO: hold the model's c_done=0 and push 17 updates with DEPTH=16 → the first is popped and 16 are buffered. wr_ready=0 with pending=16, and the 18th offer is refused. Release c_done → all 17 drain in order, runs=17.
- Simultaneous push/pop: pending=4, push on the same edge as an IDLE pop → pending stays 4 and order is preserved.
- Timeout: TIMEOUT=50, c_done never rises → exactly 50 RUN cycles, then timeouts=1, err=1, and the next entry starts. Repeat 300 times → timeouts=255.
- Mid-run reset: assert reset_n=0 during RUN with pending=3 → pending=0, FSM=IDLE. After release, no run starts until a new push.

Source files
------------

// File: rtl/update_dispatcher.sv
// update_dispatcher: FIFO-buffers host edge-weight updates and sequences the container
// reset/run/done handshake so each update triggers exactly one container pass.
//   state | meaning
//   IDLE  | c_reset low, pops the FIFO head into u_* when pending > 0
//   LOAD  | c_reset high for LOAD_CYC cycles while the container reloads
//   RUN   | waits for c_done, aborts after TIMEOUT cycles
module update_dispatcher #(
  parameter int VERT_W   = 6,
  parameter int WEIGHT_W = 32,
  parameter int DEPTH    = 16,
  parameter int LOAD_CYC = 2,
  parameter int TIMEOUT  = 65535
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     wr_valid,
  output logic                     wr_ready,
  input  logic [VERT_W-1:0]        wr_src,
  input  logic [VERT_W-1:0]        wr_dst,
  input  logic [WEIGHT_W-1:0]      wr_weight,
  output logic                     c_reset,
  output logic [VERT_W-1:0]        u_src,
  output logic [VERT_W-1:0]        u_dst,
  output logic [WEIGHT_W-1:0]      u_e,
  input  logic                     c_done,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   pending,
  output logic [15:0]              runs,
  output logic [7:0]               timeouts,
  output logic                     err
);

  localparam int AW    = $clog2(DEPTH);
  localparam int ENT_W = 2*VERT_W + WEIGHT_W;
  localparam int MAXC  = (TIMEOUT > LOAD_CYC) ? TIMEOUT : LOAD_CYC;
  localparam int CNT_W = $clog2(MAXC + 1);
  localparam logic [AW:0]      FULL_CNT  = (AW+1)'(DEPTH);
  localparam logic [CNT_W-1:0] LOAD_INIT = CNT_W'(LOAD_CYC - 1);
  localparam logic [CNT_W-1:0] RUN_INIT  = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [ENT_W-1:0]    r_mem [DEPTH];
  logic [AW-1:0]       r_wr_ptr;
  logic [AW-1:0]       r_rd_ptr;
  logic [AW:0]         r_count;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_c_reset;
  logic [VERT_W-1:0]   r_u_src;
  logic [VERT_W-1:0]   r_u_dst;
  logic [WEIGHT_W-1:0] r_u_e;
  logic [15:0]         r_runs;
  logic [7:0]          r_timeouts;
  logic                r_err;
  logic                w_push;
  logic                w_pop;
  logic                w_done;
  logic                w_abort;
  logic                w_cnt_zero;

  assign wr_ready   = (r_count != FULL_CNT);
  assign w_push     = wr_valid && wr_ready;
  assign w_cnt_zero = (r_cnt == '0);

  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_done      = 1'b0;
    w_abort     = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (r_count != '0) begin
          w_pop       = 1'b1;
          w_state_nxt = LOAD;
        end
      end
      LOAD: begin
        if (w_cnt_zero) w_state_nxt = RUN;
      end
      RUN: begin
        if (c_done) begin
          w_done      = 1'b1;
          w_state_nxt = IDLE;
        end else if (w_cnt_zero) begin
          w_abort     = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_state_nxt;
  end

  // Storage is not reset; occupancy and pointers define what is valid.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= {wr_src, wr_dst, wr_weight};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_cnt      <= '0;
      r_c_reset  <= 1'b1;
      r_u_src    <= '0;
      r_u_dst    <= '0;
      r_u_e      <= '0;
      r_runs     <= '0;
      r_timeouts <= '0;
      r_err      <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_push && !w_pop)      r_count <= r_count + 1'b1;
      else if (!w_push && w_pop) r_count <= r_count - 1'b1;
      r_c_reset <= (w_state_nxt == LOAD);
      // One down-counter times both the LOAD window and the RUN watchdog.
      if (w_pop) begin
        {r_u_src, r_u_dst, r_u_e} <= r_mem[r_rd_ptr];
        r_cnt <= LOAD_INIT;
      end else if (r_state == LOAD && w_cnt_zero) begin
        r_cnt <= RUN_INIT;
      end else if (!w_cnt_zero) begin
        r_cnt <= r_cnt - 1'b1;
      end
      if (w_done) r_runs <= r_runs + 16'd1;
      if (w_abort) begin
        r_err <= 1'b1;
        if (r_timeouts != 8'hFF) r_timeouts <= r_timeouts + 8'd1;
      end
    end
  end

  assign c_reset  = r_c_reset;
  assign u_src    = r_u_src;
  assign u_dst    = r_u_dst;
  assign u_e      = r_u_e;
  assign busy     = (r_state != IDLE);
  assign pending  = r_count;
  assign runs     = r_runs;
  assign timeouts = r_timeouts;
  assign err      = r_err;

endmodule
